// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: registers operands, waits for the
// Mul/Div path to settle, then holds the result until the consumer takes it.
// Optional divide-by-zero trap is enabled with the ALU_SEQ_DIV0_TRAP_EN macro.
module alu_sequencer #(
  parameter int MULDIV_LAT = 4,
  parameter int OPW        = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_opcode,
  input  logic           req_incpc,
  input  logic [31:0]    req_a,
  input  logic [31:0]    req_b,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  output logic [OPW-1:0] alu_opcode,
  output logic           alu_incpc,
  input  logic [31:0]    alu_hi,
  input  logic [31:0]    alu_lo,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [31:0]    z_hi,
  output logic [31:0]    z_lo,
  output logic           busy
`ifdef ALU_SEQ_DIV0_TRAP_EN
  ,
  output logic           div0
`endif
);

  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  // Highest opcode the ISA defines; anything above completes with a zero result.
  localparam logic [OPW-1:0] OP_LAST = OPW'(26);
  localparam logic [5:0]     CNT_LOAD = 6'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_e;

  state_e         state_q;
  logic [5:0]     cnt_q;
  logic [31:0]    alu_a_q;
  logic [31:0]    alu_b_q;
  logic [OPW-1:0] alu_opcode_q;
  logic           alu_incpc_q;
  logic [31:0]    z_hi_q;
  logic [31:0]    z_lo_q;
  logic           rsp_valid_q;
  logic           req_ready_q;
  logic           busy_q;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic           div0_q;
`endif

  logic           exec_is_muldiv;
  logic           exec_trap;
  logic [31:0]    z_hi_d;
  logic [31:0]    z_lo_d;

  // Result shaping for single-cycle completion out of EXEC.
  always_comb begin
    exec_is_muldiv = !alu_incpc_q &&
                     ((alu_opcode_q == OP_MUL) || (alu_opcode_q == OP_DIV));
    z_hi_d = exec_is_muldiv ? alu_hi : 32'd0;
    z_lo_d = (alu_incpc_q || (alu_opcode_q <= OP_LAST)) ? alu_lo : 32'd0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    exec_trap = !alu_incpc_q && (alu_opcode_q == OP_DIV) && (alu_b_q == 32'd0);
`else
    exec_trap = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_opcode_q <= '0;
      alu_incpc_q  <= 1'b0;
      z_hi_q       <= 32'd0;
      z_lo_q       <= 32'd0;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
      div0_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            alu_a_q      <= req_a;
            alu_b_q      <= req_b;
            alu_opcode_q <= req_opcode;
            alu_incpc_q  <= req_incpc;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
`ifdef ALU_SEQ_DIV0_TRAP_EN
            div0_q       <= 1'b0;
`endif
          end
        end
        EXEC: begin
          if (exec_trap) begin
            z_hi_q      <= 32'd0;
            z_lo_q      <= 32'd0;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ALU_SEQ_DIV0_TRAP_EN
            div0_q      <= 1'b1;
`endif
          end else if (exec_is_muldiv && (MULDIV_LAT > 1)) begin
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end else begin
            z_hi_q      <= z_hi_d;
            z_lo_q      <= z_lo_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 6'd1;
          // Capture on the edge where the counter reaches zero, so EXEC plus
          // WAIT together span exactly MULDIV_LAT cycles.
          if (cnt_q <= 6'd1) begin
            z_hi_q      <= alu_hi;
            z_lo_q      <= alu_lo;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_incpc  = alu_incpc_q;
  assign rsp_valid  = rsp_valid_q;
  assign z_hi       = z_hi_q;
  assign z_lo       = z_lo_q;
  assign busy       = busy_q;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign div0       = div0_q;
`endif

endmodule
